// File: rtl/spi_msg_engine.sv
// spi_msg_engine: round-robin port-B consumer that runs pending buffer slots as 16-bit SPI frames.
// Define SPI_LOOPBACK_EN to feed mosi back as the sampled bit instead of the miso pin.
module spi_msg_engine #(
  parameter int ADDR_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [31:0]       dib,
  input  logic [31:0]       dob,
  input  logic              ackb,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SHIFT, WB, GAP, NEXT} state_t;
  localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);
  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [5:0]        h;
  logic [29:0]       word;
  logic [15:0]       sh, frame;
  logic [7:0]        rx;
  logic [ADDR_W-1:0] ptr;
  logic              tick, pending, samp;
  assign tick    = cnt == CW'(CLK_DIV - 1);
  assign pending = dob[30] & ~dob[31];
  assign frame   = {dob[29], dob[14:8], dob[29] ? 8'h00 : dob[7:0]};
`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign samp = mosi;
`else
  assign samp = miso;
`endif
  assign enb   = state == RD_REQ || state == WB;
  assign web   = state == WB;
  assign addrb = ptr;
  assign dib   = web ? {2'b11, word[29:8], word[29] ? rx : word[7:0]} : 32'h0;
  assign busy  = state == RD_WAIT || state == SHIFT || state == WB;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = en ? RD_REQ : IDLE;
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: state_nx = ackb ? (pending ? SHIFT : NEXT) : RD_WAIT;
      SHIFT:   state_nx = (tick && h == 6'd32) ? WB : SHIFT;
      WB:      state_nx = GAP;
      GAP:     state_nx = cnt == CW'(CS_GAP - 1) ? NEXT : GAP;
      NEXT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // h counts sclk half-periods; the 33rd tick holds cs_n low one extra half-period after the last fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      h    <= '0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      cs_n <= 1'b1;
      ptr  <= '0;
      word <= '0;
      sh   <= '0;
      rx   <= '0;
    end else begin
      cnt <= ((state == SHIFT && !tick) || state == GAP) ? cnt + 1'b1 : '0;
      if (state == NEXT) ptr <= ptr + 1'b1;
      if (state == RD_WAIT && ackb) begin
        word <= dob[29:0];
        if (pending) begin
          cs_n <= 1'b0;
          mosi <= frame[15];
          sh   <= {frame[14:0], 1'b0};
          h    <= '0;
        end
      end
      if (state == SHIFT && tick) begin
        h <= h + 1'b1;
        if (h == 6'd32) cs_n <= 1'b1;
        else if (!h[0]) begin
          sclk <= 1'b1;
          rx   <= {rx[6:0], samp};
        end else begin
          sclk <= 1'b0;
          mosi <= sh[15];
          sh   <= {sh[14:0], 1'b0};
        end
      end
    end
  end
endmodule
